// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath.
// Optional feature macro: MC_CTRL_BNE_EN adds the branchNe qualifier.
interface mc_main_ctrl_if;
    logic [5:0] opCode;
    logic       memReady;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       iOrD;
    logic       memToReg;
    logic       regDst;
    logic       irWrite;
    logic       pcWrite;
    logic       branch;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memTimeout;
    logic [3:0] state;
`ifdef MC_CTRL_BNE_EN
    logic       branchNe;
`endif

    // Controller side: consumes opcode/handshake, drives selects and strobes.
    modport master (
        input  opCode, memReady,
`ifdef MC_CTRL_BNE_EN
        output branchNe,
`endif
        output aluOp, aluSrcA, aluSrcB, pcSrc, iOrD, memToReg, regDst,
        output irWrite, pcWrite, branch, memRead, memWrite, regWrite,
        output memTimeout, state
    );

    // Datapath side.
    modport slave (
        output opCode, memReady,
`ifdef MC_CTRL_BNE_EN
        input  branchNe,
`endif
        input  aluOp, aluSrcA, aluSrcB, pcSrc, iOrD, memToReg, regDst,
        input  irWrite, pcWrite, branch, memRead, memWrite, regWrite,
        input  memTimeout, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// stretches memory states on memReady and aborts to FETCH on a stuck memory.
// Optional feature macro: MC_CTRL_BNE_EN (bne decodes to BRANCH, adds branchNe).
module mc_main_ctrl #(
    parameter int TIMEOUT_CYCLES = 15   // legal 1..255
) (
    input  logic           clk,
    input  logic           rstN,
    mc_main_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // Last waiting cycle before abort: the count would reach the limit at this edge.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic       r_memTimeout;

    state_t     w_next;
    logic       w_memState;
    logic       w_abort;
    logic       w_strobeEn;

    logic [1:0] w_aluOp;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_pcSrc;
    logic       w_iOrD;
    logic       w_memToReg;
    logic       w_regDst;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic       w_branch;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_regWrite;

    // Only states that wait on memory run the timeout counter.
    assign w_memState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // memReady on the limit cycle still wins, so abort needs memReady low.
    assign w_abort    = w_memState && !bus.memReady && (r_wait == WAIT_LAST);
    // Reset kills strobes immediately; an abort cycle issues none either.
    assign w_strobeEn = rstN && !w_abort;

    // Next-state decode; unknown opcodes and illegal encodings fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opCode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BRANCH;
`endif
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = bus.memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = bus.memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register, memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_memTimeout <= 1'b0;
        end else if (w_abort) begin
            r_state      <= S_FETCH;
            r_wait       <= '0;
            r_memTimeout <= 1'b1;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_memState && !bus.memReady) ? r_wait + 8'd1 : 8'd0;
        end
    end

    // Per-state datapath selects and raw strobes; unused fields stay 0.
    always_comb begin
        w_aluOp    = 2'b00;
        w_aluSrcA  = 1'b0;
        w_aluSrcB  = 2'b00;
        w_pcSrc    = 2'b00;
        w_iOrD     = 1'b0;
        w_memToReg = 1'b0;
        w_regDst   = 1'b0;
        w_irWrite  = 1'b0;
        w_pcWrite  = 1'b0;
        w_branch   = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                w_irWrite = bus.memReady;
                w_pcWrite = bus.memReady;
            end
            S_DECODE: w_aluSrcB = 2'b11;
            S_MEMADR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                w_memRead = 1'b1;
                w_iOrD    = 1'b1;
            end
            S_MEMWB: begin
                w_regWrite = 1'b1;
                w_memToReg = 1'b1;
            end
            S_MEMWR: begin
                w_memWrite = bus.memReady;
                w_iOrD     = 1'b1;
            end
            S_EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b10;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
            end
            S_BRANCH: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b01;
                w_pcSrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_ADDIWB: w_regWrite = 1'b1;
            S_JUMP: begin
                w_pcSrc   = 2'b10;
                w_pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.aluOp      = w_aluOp;
    assign bus.aluSrcA    = w_aluSrcA;
    assign bus.aluSrcB    = w_aluSrcB;
    assign bus.pcSrc      = w_pcSrc;
    assign bus.iOrD       = w_iOrD;
    assign bus.memToReg   = w_memToReg;
    assign bus.regDst     = w_regDst;
    assign bus.irWrite    = w_irWrite  & w_strobeEn;
    assign bus.pcWrite    = w_pcWrite  & w_strobeEn;
    assign bus.branch     = w_branch   & w_strobeEn;
    assign bus.memRead    = w_memRead  & w_strobeEn;
    assign bus.memWrite   = w_memWrite & w_strobeEn;
    assign bus.regWrite   = w_regWrite & w_strobeEn;
    assign bus.memTimeout = r_memTimeout;
    assign bus.state      = r_state;
`ifdef MC_CTRL_BNE_EN
    // Tells the branch unit to invert the zero test for bne.
    assign bus.branchNe   = rstN && (r_state == S_BRANCH) && (bus.opCode == OP_BNE);
`endif

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle main control FSM for the MIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the instruction opcode held in the IR and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the 2-bit aluOp consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Stretches memory states with a memReady handshake and times out on a stuck memory.

Parameters:
- TIMEOUT_CYCLES, 15, cycles a memory state may wait for memReady before abort; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- opCode  in  6  IR[31:26], valid from DECODE onward.
- memReady  in  1  memory completes the current access this cycle.
- aluOp  out  2  00 add, 01 subtract (branch compare), 10 use funct field.
- aluSrcA  out  1  0 = PC, 1 = reg A.
- aluSrcB  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- iOrD, memToReg, regDst  out  1 each  datapath mux selects.
- irWrite, pcWrite, branch, memRead, memWrite, regWrite  out  1 each  strobes.
- memTimeout  out  1  sticky abort flag; cleared only by reset.
- state  out  4  current state encoding, for debug.

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - 12..15 are illegal and return to FETCH next cycle with all strobes 0.
- Reset (rstN low, asynchronous): state=FETCH, wait counter=0, memTimeout=0; every strobe forced 0 while rstN is low.
- Reset mid-instruction aborts immediately; no partial writes after reset asserts.
- Outputs decode combinationally from state; strobes in memory states are additionally gated by memReady.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite=pcWrite=memReady.
  - Advance to DECODE only when memReady=1; otherwise hold.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Branch on opCode:
  - 100011 lw, 101011 sw -> MEMADR.
  - 000000 R-type -> EXEC.
  - 000100 beq -> BRANCH.
  - 001000 addi -> ADDIEX.
  - 000010 j -> JUMP.
  - Any other opcode -> FETCH, no strobes.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: memRead=1, iOrD=1. Next MEMWB when memReady, else hold.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Next FETCH.
- MEMWR: memWrite=memReady, iOrD=1. Next FETCH when memReady, else hold.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0. Next FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1. Next FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Next ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0. Next FETCH.
- JUMP: pcSrc=10, pcWrite=1. Next FETCH.
- Instruction latency with memReady tied high:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
- Wait counter, active in FETCH/MEMRD/MEMWR:
  - Increments each cycle memReady=0; clears on memReady=1 or on state exit.
  - When the count reaches TIMEOUT_CYCLES with memReady still 0: set memTimeout=1, go to FETCH, counter=0, no strobe that cycle.
  - memReady=1 in the same cycle the count reaches the limit: memReady wins (normal advance).
- Don't-care outputs are driven 0; no latches.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) decodes to BRANCH; an added output branchNe (1 bit) is 1 in BRANCH for bne and 0 otherwise; aluOp=01 for both beq and bne.
- Undefined: 000101 is treated as an unknown opcode (DECODE->FETCH); the branchNe port does not exist.

Test Plan:
- Reset, memReady=1, rstN released -> cycle 0 state=0, irWrite=pcWrite=1, aluSrcB=01; cycle 1 state=1, aluSrcB=11.
- lw (100011), memReady=1 -> state sequence 0,1,2,3,4,0; MEMADR aluOp=00 aluSrcB=10; MEMWB regWrite=1 memToReg=1.
- R-type (000000) -> EXEC aluOp=10 aluSrcA=1; ALUWB regWrite=1 regDst=1. beq (000100) -> BRANCH aluOp=01 pcSrc=01 branch=1.
- sw with memReady held 0 for 3 cycles in MEMWR, TIMEOUT_CYCLES=15 -> state stays 5, memWrite=0; asserts 1 on the memReady cycle, then FETCH.
- memReady stuck 0 in MEMRD, TIMEOUT_CYCLES=4 -> after 4 waiting cycles memTimeout=1 and state=0; memTimeout stays 1 until rstN pulses.
- Opcode 111111 -> DECODE then FETCH with no strobes. rstN asserted in EXEC -> state=0 immediately, regWrite never asserts.
